// File: rtl/logic_unit_pipe_pkg.sv
// Op encodings and widths for the bitwise logic unit; shared with the ALU decoder.
package logic_unit_pipe_pkg;
  localparam int LOP_W = 3;

  typedef enum logic [LOP_W-1:0] {
    LOP_AND   = 3'd0,
    LOP_OR    = 3'd1,
    LOP_XOR   = 3'd2,
    LOP_NAND  = 3'd3,
    LOP_NOR   = 3'd4,
    LOP_XNOR  = 3'd5,
    LOP_ANDN  = 3'd6,
    LOP_PASSB = 3'd7
  } lop_e;
endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register slice; an empty slot accepts even while downstream stalls.
module logic_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  input  logic         dn_ready
);
  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      // data only moves on a real accept so bubbles never disturb it
      if (up_valid) dn_data <= up_data;
    end
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit: 8 ops, STAGES valid/ready slices, zero/ones flags.
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [LOP_W-1:0] in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ones
);
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][WIDTH-1:0]   dat_pipe;
  logic [STAGES+1:1]            rdy_pipe;
  logic [WIDTH-1:0]             op_res;

  always_comb begin
    op_res = in_b;
    case (lop_e'(in_op))
      LOP_AND:   op_res = in_a & in_b;
      LOP_OR:    op_res = in_a | in_b;
      LOP_XOR:   op_res = in_a ^ in_b;
      LOP_NAND:  op_res = ~(in_a & in_b);
      LOP_NOR:   op_res = ~(in_a | in_b);
      LOP_XNOR:  op_res = ~(in_a ^ in_b);
      LOP_ANDN:  op_res = in_a & ~in_b;
      LOP_PASSB: op_res = in_b;
      default:   op_res = in_b;
    endcase
  end

  assign vld_pipe[0]       = in_valid;
  assign dat_pipe[0]       = op_res;
  assign rdy_pipe[STAGES+1] = out_ready;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stg
    logic_pipe_stage #(.W(WIDTH)) u_stg (
      .clock    (clock),
      .reset_n  (reset_n),
      .up_valid (vld_pipe[k-1]),
      .up_data  (dat_pipe[k-1]),
      .up_ready (rdy_pipe[k]),
      .dn_valid (vld_pipe[k]),
      .dn_data  (dat_pipe[k]),
      .dn_ready (rdy_pipe[k+1])
    );
  end

  // out_ready -> in_ready is the only combinational path through the unit
  assign in_ready   = rdy_pipe[1];
  assign out_valid  = vld_pipe[STAGES];
  assign out_result = dat_pipe[STAGES];
  assign out_zero   = ~|out_result;
  assign out_ones   = &out_result;
endmodule
